// File: rtl/id_decode_stage.sv
// MIPS instruction-decode stage: splits each accepted word into fields, classifies it,
// resolves the write-back register and computes immediate/branch/jump values into one output register.
module id_decode_stage #(
  parameter int NB_ADDR = 32,
  parameter int NB_INST = 32,
  parameter int NB_REG  = 5,
  parameter int NB_DATA = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_ADDR-1:0] i_pc,
  input  logic [NB_INST-1:0] i_instruction,
  input  logic               i_flush,
  input  logic               i_ex_mem_read,
  input  logic [NB_REG-1:0]  i_ex_rt,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_hazard_stall,
  output logic [5:0]         o_opcode,
  output logic [5:0]         o_funct,
  output logic [4:0]         o_shamt,
  output logic [NB_REG-1:0]  o_rs,
  output logic [NB_REG-1:0]  o_rt,
  output logic [NB_REG-1:0]  o_rd,
  output logic [1:0]         o_type,
  output logic [NB_DATA-1:0] o_imm_ext,
  output logic [NB_ADDR-1:0] o_branch_target,
  output logic [NB_ADDR-1:0] o_jump_target,
  output logic [NB_ADDR-1:0] o_pc,
  output logic [NB_INST-1:0] o_instruction
);

  typedef enum logic [1:0] {
    TYPE_R       = 2'b00,
    TYPE_I       = 2'b01,
    TYPE_J       = 2'b10,
    TYPE_ILLEGAL = 2'b11
  } inst_type_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_LWU   = 6'h27;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [4:0]         shamt;
  logic [15:0]        imm16;
  logic [NB_REG-1:0]  field_rs;
  logic [NB_REG-1:0]  field_rt;
  logic [NB_REG-1:0]  field_rd;

  assign opcode   = i_instruction[31:26];
  assign funct    = i_instruction[5:0];
  assign shamt    = i_instruction[10:6];
  assign imm16    = i_instruction[15:0];
  assign field_rs = NB_REG'(i_instruction[25:21]);
  assign field_rt = NB_REG'(i_instruction[20:16]);
  assign field_rd = NB_REG'(i_instruction[15:11]);

  inst_type_e         dec_type;
  logic [NB_REG-1:0]  dec_rd;
  logic [NB_REG-1:0]  dec_rs;
  logic [NB_REG-1:0]  dec_rt;
  logic               rt_used;

  always_comb begin
    dec_type = TYPE_ILLEGAL;
    dec_rd   = '0;
    rt_used  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_type = TYPE_R;
        dec_rd   = field_rd;
        rt_used  = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU,
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        dec_type = TYPE_I;
        dec_rd   = field_rt;
      end
      OP_SB, OP_SH, OP_SW, OP_BEQ, OP_BNE: begin
        dec_type = TYPE_I;
        rt_used  = 1'b1;
      end
      OP_J: begin
        dec_type = TYPE_J;
      end
      OP_JAL: begin
        dec_type = TYPE_J;
        dec_rd   = NB_REG'(31);
      end
      default: begin
        dec_type = TYPE_ILLEGAL;
      end
    endcase
  end

  // Illegal words report no source registers, so they can never trigger a load-use stall.
  assign dec_rs = (dec_type == TYPE_ILLEGAL) ? '0 : field_rs;
  assign dec_rt = (dec_type == TYPE_ILLEGAL) ? '0 : field_rt;

  logic [NB_DATA-1:0] dec_imm;

  always_comb begin
    dec_imm = NB_DATA'($signed(imm16));
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI: dec_imm = NB_DATA'(imm16);
      OP_LUI:                   dec_imm = NB_DATA'({imm16, 16'h0000});
      default:                  dec_imm = NB_DATA'($signed(imm16));
    endcase
  end

  logic [NB_ADDR-1:0] pc4;
  logic [NB_ADDR-1:0] branch_target;
  logic [NB_ADDR-1:0] jump_target;

  assign pc4           = i_pc + NB_ADDR'(4);
  assign branch_target = pc4 + NB_ADDR'($signed({imm16, 2'b00}));

  generate
    if (NB_ADDR > 28) begin : g_jump_wide
      assign jump_target = {pc4[NB_ADDR-1:28], i_instruction[25:0], 2'b00};
    end else begin : g_jump_narrow
      assign jump_target = {i_instruction[25:0], 2'b00};
    end
  endgenerate

  logic hazard;
  logic accept;

  assign hazard = i_valid && i_ex_mem_read && (i_ex_rt != '0) &&
                  ((i_ex_rt == dec_rs) || (rt_used && (i_ex_rt == dec_rt)));
  assign o_hazard_stall = hazard && !i_flush;
  assign o_ready        = (!o_valid || i_ready) && !o_hazard_stall;
  assign accept         = i_valid && o_ready && !i_flush;

  // Flush outranks acceptance; a drained register keeps its fields so downstream sees stable values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid         <= 1'b0;
      o_opcode        <= '0;
      o_funct         <= '0;
      o_shamt         <= '0;
      o_rs            <= '0;
      o_rt            <= '0;
      o_rd            <= '0;
      o_type          <= '0;
      o_imm_ext       <= '0;
      o_branch_target <= '0;
      o_jump_target   <= '0;
      o_pc            <= '0;
      o_instruction   <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (accept) begin
      o_valid         <= 1'b1;
      o_opcode        <= opcode;
      o_funct         <= funct;
      o_shamt         <= shamt;
      o_rs            <= dec_rs;
      o_rt            <= dec_rt;
      o_rd            <= dec_rd;
      o_type          <= dec_type;
      o_imm_ext       <= dec_imm;
      o_branch_target <= branch_target;
      o_jump_target   <= jump_target;
      o_pc            <= i_pc;
      o_instruction   <= i_instruction;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: directed vector table, hand-written handshake
// sequences, then randomized traffic against a transaction-level reference model.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        flush;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        out_valid;
  logic        down_ready;
  logic        hazard_stall;
  logic [5:0]  opcode, funct;
  logic [4:0]  shamt, rs, rt, rd;
  logic [1:0]  itype;
  logic [31:0] imm_ext, branch_target, jump_target, out_pc, out_instruction;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  id_decode_stage dut (
    .i_clk(clk), .i_reset(reset), .i_valid(in_valid), .o_ready(out_ready),
    .i_pc(pc), .i_instruction(instruction), .i_flush(flush),
    .i_ex_mem_read(ex_mem_read), .i_ex_rt(ex_rt), .o_valid(out_valid),
    .i_ready(down_ready), .o_hazard_stall(hazard_stall),
    .o_opcode(opcode), .o_funct(funct), .o_shamt(shamt),
    .o_rs(rs), .o_rt(rt), .o_rd(rd), .o_type(itype), .o_imm_ext(imm_ext),
    .o_branch_target(branch_target), .o_jump_target(jump_target),
    .o_pc(out_pc), .o_instruction(out_instruction)
  );

  typedef struct packed {
    logic [1:0]  typ;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] br;
    logic [31:0] jt;
    logic [31:0] pc;
    logic [31:0] inst;
  } dec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [1:0]  typ;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] br;
    logic [31:0] jt;
  } vec_t;

  dec_t dut_q;
  assign dut_q = {itype, opcode, funct, shamt, rs, rt, rd, imm_ext,
                  branch_target, jump_target, out_pc, out_instruction};

  // Decoding straight from the instruction-set rules, with 32-bit wrapping arithmetic.
  function automatic dec_t model(logic [31:0] p, logic [31:0] w);
    dec_t        d;
    logic [5:0]  op  = w[31:26];
    logic [15:0] imm = w[15:0];
    logic [31:0] pc4 = p + 32'd4;
    d.opcode = op;
    d.funct  = w[5:0];
    d.shamt  = w[10:6];
    d.rs     = w[25:21];
    d.rt     = w[20:16];
    d.pc     = p;
    d.inst   = w;
    if (op == 6'h00) begin
      d.typ = 2'b00; d.rd = w[15:11];
    end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h27,
                            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F}) begin
      d.typ = 2'b01; d.rd = w[20:16];
    end else if (op inside {6'h28, 6'h29, 6'h2B, 6'h04, 6'h05}) begin
      d.typ = 2'b01; d.rd = 5'd0;
    end else if (op == 6'h02) begin
      d.typ = 2'b10; d.rd = 5'd0;
    end else if (op == 6'h03) begin
      d.typ = 2'b10; d.rd = 5'd31;
    end else begin
      d.typ = 2'b11; d.rs = 5'd0; d.rt = 5'd0; d.rd = 5'd0;
    end
    if (op inside {6'h0C, 6'h0D, 6'h0E}) d.imm = {16'h0000, imm};
    else if (op == 6'h0F)                d.imm = {imm, 16'h0000};
    else                                 d.imm = 32'($signed(imm));
    d.br = pc4 + 32'($signed(imm)) * 32'd4;
    d.jt = (pc4 & 32'hF000_0000) | ({6'b0, w[25:0]} << 2);
    return d;
  endfunction

  function automatic logic reads_rt(dec_t d);
    return (d.typ == 2'b00) || (d.opcode inside {6'h28, 6'h29, 6'h2B, 6'h04, 6'h05});
  endfunction

  task automatic applyStimulus(input logic rst, input logic v, input logic [31:0] p,
                               input logic [31:0] w, input logic fl, input logic mr,
                               input logic [4:0] ert, input logic rdy);
    reset       = rst;
    in_valid    = v;
    pc          = p;
    instruction = w;
    flush       = fl;
    ex_mem_read = mr;
    ex_rt       = ert;
    down_ready  = rdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[12];
  logic [5:0] ops[20] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
                         6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h27, 6'h28, 6'h29, 6'h2B};

  initial begin
    dec_t snap;
    dec_t m_out;
    logic m_valid;

    vecs[0]  = '{32'h0000_0100, 32'h012A_4020, 2'd0, 5'd9, 5'd10, 5'd8,  32'h0000_4020, 32'h0001_0184, 32'h04A9_0080};
    vecs[1]  = '{32'h0000_0104, 32'h2128_FFFF, 2'd1, 5'd9, 5'd8,  5'd8,  32'hFFFF_FFFF, 32'h0000_0104, 32'h04A3_FFFC};
    vecs[2]  = '{32'h0000_0108, 32'h3528_FFFF, 2'd1, 5'd9, 5'd8,  5'd8,  32'h0000_FFFF, 32'h0000_0108, 32'h04A3_FFFC};
    vecs[3]  = '{32'h0000_010C, 32'h3C08_1234, 2'd1, 5'd0, 5'd8,  5'd8,  32'h1234_0000, 32'h0000_49E0, 32'h0020_48D0};
    vecs[4]  = '{32'h0000_0200, 32'h1109_FFFF, 2'd1, 5'd8, 5'd9,  5'd0,  32'hFFFF_FFFF, 32'h0000_0200, 32'h0427_FFFC};
    vecs[5]  = '{32'h0000_0400, 32'h0C00_0010, 2'd2, 5'd0, 5'd0,  5'd31, 32'h0000_0010, 32'h0000_0444, 32'h0000_0040};
    vecs[6]  = '{32'hFFFF_FFFC, 32'h1400_0001, 2'd1, 5'd0, 5'd0,  5'd0,  32'h0000_0001, 32'h0000_0004, 32'h0000_0004};
    vecs[7]  = '{32'h0000_0500, 32'hFD2A_4020, 2'd3, 5'd0, 5'd0,  5'd0,  32'h0000_4020, 32'h0001_0584, 32'h04A9_0080};
    vecs[8]  = '{32'h0000_0600, 32'hAD28_FFF8, 2'd1, 5'd9, 5'd8,  5'd0,  32'hFFFF_FFF8, 32'h0000_05E4, 32'h04A3_FFE0};
    vecs[9]  = '{32'h0000_0700, 32'h3128_8000, 2'd1, 5'd9, 5'd8,  5'd8,  32'h0000_8000, 32'hFFFE_0704, 32'h04A2_0000};
    vecs[10] = '{32'hF000_0000, 32'h0800_0100, 2'd2, 5'd0, 5'd0,  5'd0,  32'h0000_0100, 32'hF000_0404, 32'hF000_0400};
    vecs[11] = '{32'h0000_0010, 32'h8D2A_0004, 2'd1, 5'd9, 5'd10, 5'd10, 32'h0000_0004, 32'h0000_0024, 32'h04A8_0010};

    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
    checkOutput("reset_valid", 256'(out_valid), 256'(1'b0));
    checkOutput("reset_fields", 256'(dut_q), 256'(0));
    checkOutput("reset_ready", 256'(out_ready), 256'(1'b1));
    checkOutput("reset_stall", 256'(hazard_stall), 256'(1'b0));

    // Back-to-back directed vectors at full throughput.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b1, vecs[i].pc, vecs[i].inst, 1'b0, 1'b0, 5'd0, 1'b1);
      tick();
      checkOutput($sformatf("vec%0d", i),
                  {out_valid, itype, rs, rt, rd, imm_ext, branch_target, jump_target, out_pc, out_instruction},
                  {1'b1, vecs[i].typ, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].br,
                   vecs[i].jt, vecs[i].pc, vecs[i].inst});
    end

    // Load-use stall on rs, released when the load leaves EX.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b1, 32'h800, 32'h012A_4020, 1'b0, 1'b1, 5'd9, 1'b1);
      checkOutput($sformatf("haz_stall%0d", c), {hazard_stall, out_ready}, {1'b1, 1'b0});
      tick();
      checkOutput($sformatf("haz_drain%0d", c), 256'(out_valid), 256'(1'b0));
    end
    applyStimulus(1'b0, 1'b1, 32'h800, 32'h012A_4020, 1'b0, 1'b0, 5'd9, 1'b1);
    checkOutput("haz_release", {hazard_stall, out_ready}, {1'b0, 1'b1});
    tick();
    checkOutput("haz_accept", {out_valid, rd, out_pc}, {1'b1, 5'd8, 32'h800});
    applyStimulus(1'b0, 1'b1, 32'h804, 32'h012A_4020, 1'b0, 1'b1, 5'd0, 1'b1);
    checkOutput("haz_rt0", {hazard_stall, out_ready}, {1'b0, 1'b1});
    tick();
    checkOutput("haz_rt0_acc", {out_valid, out_pc}, {1'b1, 32'h804});
    applyStimulus(1'b0, 1'b1, 32'h808, 32'h012A_4020, 1'b1, 1'b1, 5'd9, 1'b1);
    checkOutput("flush_haz", {hazard_stall, out_ready}, {1'b0, 1'b1});
    tick();
    checkOutput("flush_haz_drop", 256'(out_valid), 256'(1'b0));

    // Backpressure freezes the output, then a flush drops the pending input.
    applyStimulus(1'b0, 1'b1, 32'h900, 32'h8D2A_0004, 1'b0, 1'b0, 5'd0, 1'b1);
    tick();
    snap = model(32'h900, 32'h8D2A_0004);
    checkOutput("bp_load", {out_valid, dut_q}, {1'b1, snap});
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b1, 32'h904, 32'h2128_FFFF, 1'b0, 1'b0, 5'd0, 1'b0);
      checkOutput($sformatf("bp_ready%0d", c), 256'(out_ready), 256'(1'b0));
      tick();
      checkOutput($sformatf("bp_hold%0d", c), {out_valid, dut_q}, {1'b1, snap});
    end
    applyStimulus(1'b0, 1'b1, 32'h908, 32'h2128_FFFF, 1'b1, 1'b0, 5'd0, 1'b0);
    tick();
    checkOutput("flush_drop", 256'(out_valid), 256'(1'b0));
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1);
    tick();
    tick();
    checkOutput("flush_never", {out_valid, out_pc}, {1'b0, 32'h900});

    // Illegal opcode, then reset while it is held.
    applyStimulus(1'b0, 1'b1, 32'hA00, 32'hFD2A_4020, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    checkOutput("illegal", {out_valid, itype, rs, rt, rd, opcode}, {1'b1, 2'b11, 5'd0, 5'd0, 5'd0, 6'h3F});
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    checkOutput("mid_reset", {out_valid, dut_q}, 256'(0));

    // Randomized traffic against a transaction model of the handshake.
    m_valid = 1'b0;
    m_out   = '0;
    for (int c = 0; c < 400; c++) begin
      logic [31:0] r, rp, w, p;
      logic [5:0]  op;
      logic        v, rdy, fl, mr, rst, haz, stall, rdy_exp;
      logic [4:0]  ert;
      dec_t        d;
      r   = $urandom();
      rp  = $urandom();
      op  = ($urandom_range(0, 9) == 0) ? 6'(r[31:26]) : ops[$urandom_range(0, 19)];
      w   = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), r[15:0]};
      p   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {rp[31:2], 2'b00};
      v   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 7);
      fl  = ($urandom_range(0, 9) == 0);
      mr  = ($urandom_range(0, 9) < 3);
      ert = 5'($urandom_range(0, 3));
      rst = ($urandom_range(0, 49) == 0);
      applyStimulus(rst, v, p, w, fl, mr, ert, rdy);
      d       = model(p, w);
      haz     = v && mr && (ert != 5'd0) && ((ert == d.rs) || (reads_rt(d) && ert == d.rt));
      stall   = haz && !fl;
      rdy_exp = (!m_valid || rdy) && !stall;
      checkOutput($sformatf("rnd%0d_comb", c), {hazard_stall, out_ready}, {stall, rdy_exp});
      checkOutput($sformatf("rnd%0d_reg", c), {out_valid, dut_q}, {m_valid, m_out});
      if (rst) begin
        m_valid = 1'b0;
        m_out   = '0;
      end else if (fl) begin
        m_valid = 1'b0;
      end else if (v && rdy_exp) begin
        m_valid = 1'b1;
        m_out   = d;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
      tick();
    end
    checkOutput("rnd_final", {out_valid, dut_q}, {m_valid, m_out});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/id_decode_stage.md
# id_decode_stage

Registered MIPS instruction-decode stage between the fetch stage and the ID/EX boundary. Each accepted instruction is split into its fields and classified as R, I, J or illegal. The stage also resolves the write-back register, extends the immediate, and computes branch and jump targets. A valid/ready handshake, load-use hazard stall and flush control move instructions through one output register.

## Interface
Parameters:
- NB_ADDR, 32, PC width; must be ≥ 28.
- NB_INST, 32, instruction width; field positions are fixed MIPS32.
- NB_REG, 5, register-index width.
- NB_DATA, 32, width of the extended immediate.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  reset; synchronous, active-high.
- i_valid  in  1  i_pc/i_instruction valid from fetch.
- o_ready  out  1  stage accepts input this cycle.
- i_pc  in  NB_ADDR  address of i_instruction.
- i_instruction  in  NB_INST  instruction word.
- i_flush  in  1  squash held and incoming instruction.
- i_ex_mem_read  in  1  instruction in EX is a load.
- i_ex_rt  in  NB_REG  destination register of the load in EX.
- o_valid  out  1  output register holds a decoded instruction.
- i_ready  in  1  downstream accepts the output.
- o_hazard_stall  out  1  load-use stall active (combinational).
- o_opcode  out  6, o_funct  out  6, o_shamt  out  5  raw fields.
- o_rs  out  NB_REG, o_rt  out  NB_REG  source register indices.
- o_rd  out  NB_REG  resolved write-back register; 0 means no write.
- o_type  out  2  instruction class: 00 R, 01 I, 10 J, 11 illegal.
- o_imm_ext  out  NB_DATA  extended immediate.
- o_branch_target  out  NB_ADDR, o_jump_target  out  NB_ADDR.
- o_pc  out  NB_ADDR, o_instruction  out  NB_INST  pass-through copies of the accepted pc and word.

## Operation
Decode classes:
- **R:** opcode 0x00. o_rd = inst[15:11].
- **I:** LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, LWU 0x27, SB 0x28, SH 0x29, SW 0x2B, ADDI 0x08, SLTI 0x0A, ANDI 0x0C, ORI 0x0D, XORI 0x0E, LUI 0x0F, BEQ 0x04, BNE 0x05.
  - o_rd = inst[20:16] for loads and ALU-immediates.
  - o_rd = 0 for stores and branches.
- **J:** J 0x02 gives o_rd = 0. JAL 0x03 gives o_rd = 31.
- **Illegal:** any other opcode. o_type = 11, o_rs/o_rt/o_rd = 0, other fields still captured, o_valid still asserted.

Immediate and target arithmetic:
- o_imm_ext:
  - ANDI/ORI/XORI: zero-extend inst[15:0].
  - LUI: {inst[15:0], 16'b0}, zero-extended to NB_DATA.
  - All others: sign-extend inst[15:0].
- pc4 = i_pc + 4, modulo 2^NB_ADDR.
- o_branch_target = pc4 + (sext(inst[15:0]) << 2), modulo 2^NB_ADDR; computed for every class.
- o_jump_target = {pc4[NB_ADDR-1:28], inst[25:0], 2'b00}.

Hazard and handshake:
- rt_used is true for R-type, stores, BEQ and BNE.
- hazard = i_valid && i_ex_mem_read && i_ex_rt != 0 && (i_ex_rt == rs || (rt_used && i_ex_rt == rt)).
- o_hazard_stall = hazard && !i_flush.
- o_ready = (!o_valid || i_ready) && !o_hazard_stall.
- accept = i_valid && o_ready && !i_flush.

Register update priority per edge (highest first):
1. i_reset: all outputs cleared.
2. i_flush: o_valid ← 0.
3. accept: load decoded fields, o_valid ← 1.
4. o_valid && i_ready: o_valid ← 0; fields hold their last value.
5. Otherwise: hold.

## Timing
- Reset values: o_valid = 0 and every registered output = 0. o_ready = 1 and o_hazard_stall = 0 while i_reset is low and inputs are idle.
- Latency: 1 cycle from accept to o_valid. Full throughput of one instruction per cycle when i_ready is held high.
- Backpressure: while o_valid && !i_ready, the outputs are frozen and o_ready = 0.
- A hazard blocks acceptance and does not disturb the held output. The stall releases combinationally on the cycle i_ex_mem_read falls.
- Flush and accept in the same cycle: flush wins; the input is dropped and o_valid = 0 next cycle.
- Flush and hazard in the same cycle: flush wins and o_hazard_stall = 0.
- Reset asserted mid-stream: the held instruction is lost. o_valid = 0 on the cycle after reset is sampled.
- Address wrap: i_pc = 0xFFFFFFFC gives pc4 = 0x00000000; target arithmetic wraps with no flag.

## Test plan
- **R-type:** Reset, then send ADD 0x012A4020 at pc 0x100 with i_ready = 1. Next cycle: o_valid = 1, o_type = 00, rs = 9, rt = 10, rd = 8, funct = 0x20, o_pc = 0x100.
- **Immediate extension:** ADDI 0x2128FFFF → imm_ext = 0xFFFFFFFF, rd = 8. ORI 0x3528FFFF → imm_ext = 0x0000FFFF. LUI 0x3C081234 → imm_ext = 0x12340000.
- **Targets and wrap:** BEQ 0x1109FFFF at pc 0x200 → branch_target = 0x200, rd = 0. JAL 0x0C000010 at pc 0x400 → jump_target = 0x40, rd = 31. Branch at pc 0xFFFFFFFC with imm 0x0001 → branch_target = 0x4.
- **Load-use hazard:** i_ex_mem_read = 1, i_ex_rt = 9, input ADD with rs = 9 → o_ready = 0 and o_hazard_stall = 1 until i_ex_mem_read falls, then accepted. The same case with i_ex_rt = 0 gives no stall.
- **Backpressure and flush:** Hold i_ready = 0 for 3 cycles → outputs stable and o_ready = 0. Then assert i_flush together with a valid input → o_valid = 0 next cycle and the input is never emitted.
- **Illegal opcode and reset:** Opcode 0x3F → o_type = 11, rs/rt/rd = 0, o_valid = 1. Assert i_reset while o_valid = 1 → all outputs 0 the next cycle.
